instr_fetch_unit: RTL

- Multi-cycle fetch stage of KGP-RISC, directly upstream of the opcode decoder.
- Holds the PC and handshakes with instruction memory.
- Presents the fetched instruction (opcode = instr[31:26]) to the controller and holds it until execute signals completion.
- Computes next PC from the decoder's lblSel/jmpSel plus the resolved branch condition, and supplies pc+4 as the link address for bl.

---
 rtl/instr_fetch_unit_if.sv | 21 ++
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory fetch bus between fetch unit and imem
interface instr_fetch_unit_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid;
    logic [31:0] imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemValid,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemValid,
        output imemData
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - KGP-RISC multi-cycle fetch stage: PC, imem handshake, next-PC select
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    instr_fetch_unit_if.master          bus,
    output logic [31:0]                 instr,
    output logic [5:0]                  opcode,
    output logic                        instrValid,
    input  logic                        lblSel,
    input  logic                        jmpSel,
    input  logic                        brTaken,
    input  logic [31:0]                 rsValue,
    input  logic                        exDone,
    input  logic                        halt,
    output logic [31:0]                 pc,
    output logic [31:0]                 linkAddr,
    output logic                        misalign,
    output logic                        fetchTimeout,
    output logic [31:0]                 retired
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        HOLD   = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          req_c;
    logic          valid_c;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   pc_plus4;
    logic [31:0]   off16;
    logic [31:0]   off26;
    logic [31:0]   target_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        valid_c    = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                req_c      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.imemValid) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                valid_c = 1'b1;
                if (exDone) begin
                    state_next = halt ? HALTED : REQ;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Branch offsets are word offsets: sign-extend, then scale by 4.
    assign pc_plus4 = pc + 32'd4;
    assign off16    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign off26    = {{4{instr[25]}}, instr[25:0], 2'b00};

    always_comb begin
        target_raw = pc_plus4;
        if (jmpSel) begin
            target_raw = rsValue;
        end else if (brTaken && lblSel) begin
            target_raw = pc_plus4 + off16;
        end else if (brTaken) begin
            target_raw = pc_plus4 + off26;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= RESET_PC;
            instr        <= 32'd0;
            wait_cnt     <= '0;
            misalign     <= 1'b0;
            fetchTimeout <= 1'b0;
            retired      <= 32'd0;
        end else begin
            misalign <= 1'b0;
            case (state)
                REQ: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (bus.imemValid) begin
                        instr    <= bus.imemData;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Saturate so a very late response cannot re-arm the flag via wrap.
                        fetchTimeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (exDone) begin
                        retired  <= retired + 32'd1;
                        pc       <= {target_raw[31:2], 2'b00};
                        misalign <= |target_raw[1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.imemReq  = req_c;
    assign bus.imemAddr = pc;
    assign instrValid   = valid_c;
    assign opcode       = instr[31:26];
    assign linkAddr     = pc_plus4;

endmodule
